// File: rtl/mem_lane_unit_if.sv
// Request/response and data-RAM bus of the memory lane unit.
// slave = the unit itself; master = the MEM stage plus the RAM.
interface mem_lane_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_exc;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_exc,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_exc,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lane_unit.sv
// Data-memory access unit: store lane steering / byte enables, load extraction
// and extension, one request at a time, with misalignment exception.
module mem_lane_unit_lane #(
    parameter int LANE   = 0,
    parameter int LANE_W = 8
) (
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic [LANE_W-1:0] byte_src,
    input  logic [LANE_W-1:0] half_src,
    input  logic [LANE_W-1:0] word_src,
    output logic              we,
    output logic [LANE_W-1:0] wbyte
);
    localparam logic [1:0] IDX = 2'(LANE);

    always_comb begin
        we    = 1'b0;
        wbyte = word_src;
        case (size)
            2'b00:   begin we = (off == IDX);       wbyte = byte_src; end
            2'b01:   begin we = (off[1] == IDX[1]); wbyte = half_src; end
            2'b10:   begin we = 1'b1;               wbyte = word_src; end
            default: ;
        endcase
    end
endmodule

module mem_lane_unit #(
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_lane_unit_if.slave  bus
);
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       sign;
        logic [1:0] off;
    } req_t;

    state_t state, nstate;
    req_t   req_q;
    logic [1:0] cnt, cnt_d;
    logic accept, illegal, lat_done;

    logic [NUM_LANES-1:0]             lane_we;
    logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    logic        ready_d, en_d, rv_d, exc_d;
    logic [3:0]  we_d;
    logic [31:0] addr_d, wdata_d, rdata_d;

    // Each lane picks the source byte for its position under byte/half/word replication.
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        mem_lane_unit_lane #(.LANE(g), .LANE_W(LANE_W)) u_lane (
            .size     (bus.req_size),
            .off      (bus.req_addr[1:0]),
            .byte_src (bus.req_wdata[LANE_W-1:0]),
            .half_src (bus.req_wdata[LANE_W*(g%2) +: LANE_W]),
            .word_src (bus.req_wdata[LANE_W*g +: LANE_W]),
            .we       (lane_we[g]),
            .wbyte    (lane_wdata[g])
        );
    end

    assign accept   = (state == IDLE) && bus.req_valid && bus.req_ready;
    assign illegal  = (bus.req_size == 2'b11)
                   || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    assign lat_done = (cnt == 2'(MEM_LAT - 1));

    assign ld_byte = bus.mem_rdata[{req_q.off, 3'b000} +: 8];
    assign ld_half = req_q.off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        case (req_q.size)
            2'b00:   ld_data = {{24{req_q.sign & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{req_q.sign & ld_half[15]}}, ld_half};
            default: ld_data = bus.mem_rdata;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            req_q          <= '0;
            bus.req_ready  <= 1'b0;
            bus.mem_en     <= 1'b0;
            bus.mem_we     <= '0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_exc   <= 1'b0;
        end else begin
            state          <= nstate;
            cnt            <= cnt_d;
            if (accept)
                req_q <= '{we: bus.req_we, size: bus.req_size, sign: bus.req_sign,
                           off: bus.req_addr[1:0]};
            bus.req_ready  <= ready_d;
            bus.mem_en     <= en_d;
            bus.mem_we     <= we_d;
            bus.mem_addr   <= addr_d;
            bus.mem_wdata  <= wdata_d;
            bus.resp_valid <= rv_d;
            bus.resp_rdata <= rdata_d;
            bus.resp_exc   <= exc_d;
        end
    end

    always_comb begin
        nstate = state;
        cnt_d  = cnt;
        case (state)
            IDLE:  if (accept) nstate = illegal ? RESP : ISSUE;
            ISSUE: begin
                cnt_d  = '0;
                nstate = req_q.we ? RESP : WAIT;
            end
            WAIT:  if (lat_done) nstate = RESP;
                   else          cnt_d  = cnt + 2'd1;
            RESP:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Next values of the output registers; memory strobes are set at accept so
    // they are visible exactly during ISSUE.
    always_comb begin
        ready_d = (nstate == IDLE);
        en_d    = 1'b0;
        we_d    = '0;
        addr_d  = bus.mem_addr;
        wdata_d = bus.mem_wdata;
        rv_d    = 1'b0;
        rdata_d = bus.resp_rdata;
        exc_d   = bus.resp_exc;
        case (state)
            IDLE: if (accept) begin
                if (illegal) begin
                    rv_d    = 1'b1;
                    exc_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    en_d    = 1'b1;
                    addr_d  = {bus.req_addr[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    if (bus.req_we) we_d = lane_we;
                end
            end
            ISSUE: if (req_q.we) begin
                rv_d    = 1'b1;
                exc_d   = 1'b0;
                rdata_d = '0;
            end
            WAIT: if (lat_done) begin
                rv_d    = 1'b1;
                exc_d   = 1'b0;
                rdata_d = ld_data;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_lane_unit.md
Name: mem_lane_unit

Overview:
- Data-memory access unit for the pipelined MIPS core; the store-side counterpart of immediate/load extension.
- Stores: narrows and positions sb/sh/sw data into byte lanes and generates byte write enables.
- Loads: issues a read, waits a fixed memory latency, then extracts the addressed byte/halfword and sign- or zero-extends it to 32 bits.
- Sits between the MEM stage and the synchronous data RAM. Provides a one-request-at-a-time valid/ready handshake and a misalignment exception flag.

Parameters:
MEM_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_sign  input  1  load extension: 1 sign, 0 zero (ignored for stores/word)
req_addr  input  32  byte address
req_wdata  input  32  store data, valid bits right-aligned
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores/exceptions
resp_exc  output  1  misaligned/illegal request, qualified by resp_valid
mem_en  output  1  memory access strobe, one cycle
mem_we  output  4  byte write enables, bit i = byte lane i (bits [8i+7:8i])
mem_addr  output  32  word address {addr[31:2],2'b00}
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read word, sampled MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, latency counter=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_exc=0.
  - req_ready=0 while rst_n=0, 1 after release.
  - Reset mid-operation aborts the request with no response; mem_we drops immediately.
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Accept: in IDLE with req_valid=1 (cycle T), latch we/size/sign/addr/wdata.
- Misalignment check at accept:
  - size=01 with addr[0]=1, size=10 with addr[1:0]!=0, or size=11 is illegal.
  - Illegal -> RESP directly: resp_valid=1 at T+1 with resp_exc=1, resp_rdata=0. No memory access.
- IDLE->ISSUE for a legal request. In ISSUE (T+1): mem_en=1 and mem_addr=word address.
- Store lanes:
  - byte: mem_we=4'b0001<<addr[1:0], mem_wdata={4{wdata[7:0]}}.
  - half: mem_we = addr[1] ? 4'b1100 : 4'b0011, mem_wdata={2{wdata[15:0]}}.
  - word: mem_we=4'b1111, mem_wdata=wdata.
  - ISSUE->RESP; resp_valid=1 at T+2, resp_rdata=0, resp_exc=0.
- Load:
  - ISSUE drives mem_we=0, then ISSUE->WAIT.
  - WAIT counts MEM_LAT cycles. mem_rdata is sampled in the cycle MEM_LAT after the ISSUE cycle.
  - Extract: byte = rdata[8*addr[1:0]+:8]; half = addr[1] ? rdata[31:16] : rdata[15:0]; word = rdata.
  - Extend per req_sign.
  - WAIT->RESP; resp_valid=1 at T+2+MEM_LAT.
- RESP->IDLE after one cycle.
  - resp_valid is a single-cycle pulse with no backpressure.
  - resp_rdata/resp_exc hold their values until the next response.
  - Next accept is possible in the cycle after RESP.
- mem_en and mem_we are high for exactly one cycle per legal request and are 0 in every other state.
- req_valid during non-IDLE states is ignored; the requester must hold it until req_ready.
- MEM_LAT outside 1..4 is a configuration error; the bench checks it via assertion.

Test Plan:
- sb: addr=0x0000_1003, wdata=0x1234_56AB -> ISSUE cycle: mem_we=4'b1000, mem_wdata=0xABAB_ABAB, mem_addr=0x0000_1000; resp_valid at T+2, resp_rdata=0.
- lh signed, MEM_LAT=1: addr=0x12, mem_rdata=0x8001_7FFF -> resp_rdata=0xFFFF_8001 at T+3. Repeat with lhu -> 0x0000_8001.
- lb signed, MEM_LAT=3: addr=0x1, mem_rdata=0x0000_F000 -> resp_rdata=0xFFFF_FFF0 at T+5. Zero-extend variant -> 0x0000_00F0.
- Misaligned: sw at addr=0x6 and lh at addr=0x3 -> resp_valid at T+1, resp_exc=1, mem_en never asserted.
- Back-to-back: sw 0xDEADBEEF at 0x20, then lw at 0x20 with the RAM model -> req_ready low during service; lw returns 0xDEADBEEF.
- Reset: deassert rst_n during WAIT of a load -> outputs 0 immediately, no resp_valid. After release, a new sb completes normally.
